clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl_if.sv | 27 ++
 rtl/clk_div_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Control and status bundle for the programmable clock divider.
// The master drives the run request and the divisor handshake.
// The slave (the divider) returns the divided clock, the edge ticks and the status.
interface clk_div_ctrl_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick_rise;
    logic             tick_fall;
    logic             cfg_err;
    logic [DIV_W-1:0] active_div;
    logic             running;

    modport master (
        output en, cfg_div, cfg_valid,
        input  cfg_ready, clk_out, tick_rise, tick_fall, cfg_err, active_div, running
    );

    modport slave (
        input  en, cfg_div, cfg_valid,
        output cfg_ready, clk_out, tick_rise, tick_fall, cfg_err, active_div, running
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider.
// The output clock has a half-period of active_div input cycles.
// A new divisor requested while running takes effect only at a falling edge of clk_out.
// Disabling the divider never cuts a high phase short.
module clk_div_ctrl #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    clk_div_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick_rise;
    logic             r_tick_fall;
    logic             r_cfg_err;
    logic [DIV_W-1:0] r_active_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend_vld;

    state_t           w_eff_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_clk_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_err_nxt;
    logic [DIV_W-1:0] w_act_nxt;
    logic [DIV_W-1:0] w_pdiv_nxt;
    logic             w_pvld_nxt;

    logic             w_cfg_ready;
    logic             w_accept;
    logic             w_acc_zero;
    logic             w_acc_new;
    logic             w_term;

    assign w_cfg_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_accept    = bus.cfg_valid && w_cfg_ready;
    assign w_acc_zero  = w_accept && (bus.cfg_div == '0);
    assign w_acc_new   = w_accept && (bus.cfg_div != '0);
    assign w_term      = (r_cnt == (r_active_div - DIV_W'(1)));

    // Re-enabling during STOPPING resumes normal running, pending divisor included.
    always_comb begin
        w_eff_state = r_state;
        if ((r_state == ST_STOP) && bus.en) begin
            w_eff_state = r_pend_vld ? ST_PEND : ST_RUN;
        end
    end

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        w_state_nxt = w_eff_state;
        w_cnt_nxt   = r_cnt;
        w_clk_nxt   = r_clk;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_err_nxt   = w_acc_zero;
        w_act_nxt   = r_active_div;
        w_pdiv_nxt  = r_pend_div;
        w_pvld_nxt  = r_pend_vld;

        case (w_eff_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                if (w_acc_new) begin
                    w_act_nxt = bus.cfg_div;
                end
                if (bus.en) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN, ST_PEND: begin
                if (w_term) begin
                    w_cnt_nxt  = '0;
                    w_clk_nxt  = ~r_clk;
                    w_rise_nxt = ~r_clk;
                    w_fall_nxt = r_clk;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end

                // A divisor accepted on a falling edge is not applied until the next one,
                // because the apply below only looks at an already-registered pending value.
                if (w_acc_new) begin
                    w_pdiv_nxt  = bus.cfg_div;
                    w_pvld_nxt  = 1'b1;
                    w_state_nxt = ST_PEND;
                end
                if (w_term && r_clk && r_pend_vld) begin
                    w_act_nxt   = r_pend_div;
                    w_pvld_nxt  = 1'b0;
                    w_state_nxt = ST_RUN;
                end

                if (!bus.en) begin
                    if (!r_clk || w_term) begin
                        // Low phase (or the high phase ends right now): park in IDLE at once.
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_clk_nxt   = 1'b0;
                        w_rise_nxt  = 1'b0;
                        if (w_acc_new) begin
                            w_act_nxt = bus.cfg_div;
                        end else if (r_pend_vld) begin
                            w_act_nxt = r_pend_div;
                        end
                        w_pvld_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (w_term) begin
                    w_cnt_nxt   = '0;
                    w_clk_nxt   = 1'b0;
                    w_fall_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (r_pend_vld) begin
                        w_act_nxt = r_pend_div;
                    end
                    w_pvld_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
        endcase
    end

    // State register; reset overrides every in-flight toggle or pending update.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_clk        <= 1'b0;
            r_tick_rise  <= 1'b0;
            r_tick_fall  <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_active_div <= DIV_W'(DEFAULT_DIV);
            r_pend_vld   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_clk        <= w_clk_nxt;
            r_tick_rise  <= w_rise_nxt;
            r_tick_fall  <= w_fall_nxt;
            r_cfg_err    <= w_err_nxt;
            r_active_div <= w_act_nxt;
            r_pend_vld   <= w_pvld_nxt;
        end
    end

    // Pending divisor storage; its valid flag alone decides whether it is used.
    always_ff @(posedge clk_in) begin
        r_pend_div <= w_pdiv_nxt;
    end

    assign bus.cfg_ready  = w_cfg_ready;
    assign bus.clk_out    = r_clk;
    assign bus.tick_rise  = r_tick_rise;
    assign bus.tick_fall  = r_tick_fall;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.active_div = r_active_div;
    assign bus.running    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset values, nominal division, divisor change,
// zero-divisor rejection, both stop paths, divide-by-one and reset in the middle of PEND.
module tb_clk_div_ctrl;

    logic clk_in = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_ctrl_if #(.DIV_W(16)) u_if ();

    clk_div_ctrl #(.DIV_W(16), .DEFAULT_DIV(16)) u_dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (u_if)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Count clocks until clk_out reaches lvl (bounded), then compare the count.
    task automatic wait_level(input logic lvl, input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((u_if.clk_out !== lvl) && (n < 200));
        check_val(tag, n, exp_n);
    endtask

    initial begin
        reset         = 1'b1;
        u_if.en        = 1'b0;
        u_if.cfg_valid = 1'b0;
        u_if.cfg_div   = '0;
        repeat (3) tick();
        check_val("rst_clk",   u_if.clk_out,    0);
        check_val("rst_rise",  u_if.tick_rise,  0);
        check_val("rst_fall",  u_if.tick_fall,  0);
        check_val("rst_err",   u_if.cfg_err,    0);
        check_val("rst_run",   u_if.running,    0);
        check_val("rst_div",   u_if.active_div, 16);

        reset = 1'b0;
        tick();
        check_val("post_rst_rdy", u_if.cfg_ready, 1);
        check_val("post_rst_run", u_if.running,   0);

        // Nominal divide by 16
        u_if.en = 1'b1;
        tick();
        check_val("run_on",   u_if.running, 1);
        check_val("run_clk0", u_if.clk_out, 0);
        wait_level(1'b1, "first_rise", 16);
        check_val("rise_tick", u_if.tick_rise, 1);
        wait_level(1'b0, "high_len", 16);
        check_val("fall_tick",    u_if.tick_fall, 1);
        check_val("fall_no_rise", u_if.tick_rise, 0);
        wait_level(1'b1, "low_len", 16);
        check_val("rise_tick2", u_if.tick_rise, 1);
        tick();
        check_val("rise_width", u_if.tick_rise, 0);
        check_val("high_hold",  u_if.clk_out,   1);

        // Zero divisor is rejected
        u_if.cfg_div   = 16'd0;
        u_if.cfg_valid = 1'b1;
        tick();
        u_if.cfg_valid = 1'b0;
        check_val("zero_err",   u_if.cfg_err,    1);
        check_val("zero_div",   u_if.active_div, 16);
        check_val("zero_rdy",   u_if.cfg_ready,  1);
        tick();
        check_val("zero_err_w", u_if.cfg_err,    0);
        tick();

        // Divisor 4 accepted 5 cycles into the high phase
        u_if.cfg_div   = 16'd4;
        u_if.cfg_valid = 1'b1;
        tick();
        u_if.cfg_valid = 1'b0;
        check_val("pend_rdy", u_if.cfg_ready,  0);
        check_val("pend_div", u_if.active_div, 16);
        check_val("pend_clk", u_if.clk_out,    1);
        wait_level(1'b0, "pend_high_rest", 11);
        check_val("new_div",     u_if.active_div, 4);
        check_val("new_div_rdy", u_if.cfg_ready,  1);
        wait_level(1'b1, "new_low",  4);
        wait_level(1'b0, "new_high", 4);

        // Stop during a low phase: IDLE next cycle, no ticks
        u_if.en = 1'b0;
        tick();
        check_val("stoplo_run",  u_if.running,   0);
        check_val("stoplo_clk",  u_if.clk_out,   0);
        check_val("stoplo_rise", u_if.tick_rise, 0);
        check_val("stoplo_fall", u_if.tick_fall, 0);
        tick();
        check_val("stoplo_hold", u_if.clk_out,   0);

        // Stop during a high phase with 3 cycles left
        u_if.en = 1'b1;
        wait_level(1'b1, "restart_rise", 5);
        tick();
        u_if.en = 1'b0;
        tick();
        check_val("stophi_run", u_if.running, 1);
        check_val("stophi_clk", u_if.clk_out, 1);
        wait_level(1'b0, "stophi_fall", 2);
        check_val("stophi_tick", u_if.tick_fall, 1);
        check_val("stophi_idle", u_if.running,   0);
        tick();
        check_val("stophi_clk0",  u_if.clk_out,   0);
        check_val("stophi_tick0", u_if.tick_fall, 0);

        // Divide by one
        u_if.cfg_div   = 16'd1;
        u_if.cfg_valid = 1'b1;
        tick();
        u_if.cfg_valid = 1'b0;
        check_val("div1_load", u_if.active_div, 1);
        u_if.en = 1'b1;
        tick();
        check_val("div1_run",   u_if.running,   1);
        check_val("div1_clk_a", u_if.clk_out,   0);
        tick();
        check_val("div1_clk_b", u_if.clk_out,   1);
        check_val("div1_rise_b", u_if.tick_rise, 1);
        check_val("div1_fall_b", u_if.tick_fall, 0);
        tick();
        check_val("div1_clk_c", u_if.clk_out,   0);
        check_val("div1_rise_c", u_if.tick_rise, 0);
        check_val("div1_fall_c", u_if.tick_fall, 1);
        tick();
        check_val("div1_clk_d", u_if.clk_out,   1);
        check_val("div1_rise_d", u_if.tick_rise, 1);

        // Reset while PEND and clk_out high
        reset   = 1'b1;
        u_if.en = 1'b0;
        tick();
        reset   = 1'b0;
        u_if.en = 1'b1;
        wait_level(1'b1, "r41_rise", 17);
        tick();
        u_if.cfg_div   = 16'd7;
        u_if.cfg_valid = 1'b1;
        tick();
        u_if.cfg_valid = 1'b0;
        check_val("r41_pend_rdy", u_if.cfg_ready, 0);
        check_val("r41_pend_clk", u_if.clk_out,   1);
        reset = 1'b1;
        tick();
        check_val("r41_clk",  u_if.clk_out,    0);
        check_val("r41_rise0", u_if.tick_rise, 0);
        check_val("r41_fall0", u_if.tick_fall, 0);
        check_val("r41_err",  u_if.cfg_err,    0);
        check_val("r41_run",  u_if.running,    0);
        check_val("r41_div",  u_if.active_div, 16);
        check_val("r41_rdy",  u_if.cfg_ready,  1);
        reset = 1'b0;
        wait_level(1'b1, "r41_rerise", 17);
        check_val("r41_div_a", u_if.active_div, 16);
        wait_level(1'b0, "r41_high", 16);
        check_val("r41_div_b", u_if.active_div, 16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
